// File: rtl/snoop_pkg.sv
// ---------------------------------------------------------------------------
// snoop_pkg
// Shared types for the MSI snooping-coherence subsystem:
//   msi_t       - per-line coherence state (I/S/M)
//   bus_msg_t   - snooped bus transaction kind
//   bus_state_t - shared bus sequencer state
// ---------------------------------------------------------------------------
package snoop_pkg;

    typedef enum logic [1:0] {
        MSI_I = 2'd0,
        MSI_S = 2'd1,
        MSI_M = 2'd2
    } msi_t;

    typedef enum logic [1:0] {
        MSG_NONE   = 2'd0,
        MSG_BUSRD  = 2'd1,
        MSG_BUSRDX = 2'd2,
        MSG_UPGR   = 2'd3
    } bus_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer. The search starts at
// the pointer; when a grant is taken (advance=1) the pointer moves to the
// winner + 1 so the winner has lowest priority next time.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req[N]       : requesters
//   advance      : consume the current grant and rotate the pointer
//   grant[N]     : one-hot winner (combinational), 0 when req is 0
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic [PTR_W-1:0] cand;
        logic             found;
        grant = '0;
        win   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                win         = cand;
                found       = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/snoop_msi_bus.sv
// ---------------------------------------------------------------------------
// snoop_msi_bus
// NPROC private direct-mapped MSI caches sharing one snooped bus and a
// word-addressed memory. Hits complete locally in one cycle; misses and
// upgrades run IDLE -> SNOOP -> FILL -> DONE on the bus.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   req_valid/req_write    : per-processor request, held until req_ready
//   req_addr/req_wdata     : packed per-processor address / write data
//   req_ready/resp_data    : one-cycle completion pulse with read/written data
//   bus_grant/bus_msg/bus_addr : current bus owner, message and address
//   wb_valid               : a memory write-back happens this cycle
// ---------------------------------------------------------------------------
module snoop_msi_bus
    import snoop_pkg::*;
#(
    parameter int NPROC  = 3,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int LINES  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NPROC-1:0]        req_valid,
    input  logic [NPROC-1:0]        req_write,
    input  logic [NPROC*ADDR_W-1:0] req_addr,
    input  logic [NPROC*DATA_W-1:0] req_wdata,
    output logic [NPROC-1:0]        req_ready,
    output logic [NPROC*DATA_W-1:0] resp_data,
    output logic [NPROC-1:0]        bus_grant,
    output logic [1:0]              bus_msg,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic                    wb_valid
);
    localparam int IDX_W     = $clog2(LINES);
    localparam int TAG_W     = (ADDR_W > IDX_W) ? ADDR_W - IDX_W : 1;
    localparam int OWN_W     = $clog2(NPROC);
    localparam int MEM_WORDS = 1 << ADDR_W;
    localparam logic [NPROC-1:0] ONE_HOT0 = 1;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    function automatic idx_t idx_of(input addr_t a);
        return a[IDX_W-1:0];
    endfunction

    function automatic tag_t tag_of(input addr_t a);
        return tag_t'(a >> IDX_W);
    endfunction

    function automatic addr_t addr_of(input tag_t t, input idx_t i);
        return addr_t'(addr_t'(t) << IDX_W) | addr_t'(i);
    endfunction

    msi_t  line_state [NPROC][LINES];
    tag_t  line_tag   [NPROC][LINES];
    data_t line_data  [NPROC][LINES];
    data_t mem        [MEM_WORDS];

    bus_state_t       state;
    logic [OWN_W-1:0] owner;
    bus_msg_t         msg;
    addr_t            addr_r;
    logic             in_txn;

    assign in_txn = (state != ST_IDLE);

    // Unpacked per-processor views of the packed request buses.
    addr_t p_addr  [NPROC];
    data_t p_wdata [NPROC];

    always_comb begin
        for (int p = 0; p < NPROC; p++) begin
            p_addr[p]  = req_addr[p*ADDR_W +: ADDR_W];
            p_wdata[p] = req_wdata[p*DATA_W +: DATA_W];
        end
    end

    // Request decode. A request is ignored while its ack is showing, and the
    // bus owner's request is not looked at again until its transaction ends.
    logic [NPROC-1:0] hit;
    logic [NPROC-1:0] need;
    bus_msg_t         need_msg [NPROC];

    always_comb begin
        msi_t st;
        logic match;
        logic active;
        st     = MSI_I;
        match  = 1'b0;
        active = 1'b0;
        for (int p = 0; p < NPROC; p++) begin
            st     = line_state[p][idx_of(p_addr[p])];
            match  = (line_tag[p][idx_of(p_addr[p])] == tag_of(p_addr[p]));
            active = req_valid[p] && !req_ready[p] && !(in_txn && owner == OWN_W'(p));
            hit[p]  = active && match && (req_write[p] ? (st == MSI_M) : (st != MSI_I));
            need[p] = active && !hit[p];
            if (!req_write[p])
                need_msg[p] = MSG_BUSRD;
            else if (match && st == MSI_S)
                need_msg[p] = MSG_UPGR;
            else
                need_msg[p] = MSG_BUSRDX;
        end
    end

    // Arbitration only happens in IDLE; the pointer advances on each grant.
    logic [NPROC-1:0] arb_req;
    logic [NPROC-1:0] arb_grant;
    logic [OWN_W-1:0] winner;

    assign arb_req = (state == ST_IDLE) ? need : '0;

    rr_arbiter #(.N(NPROC)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (arb_req),
        .advance (|arb_grant),
        .grant   (arb_grant)
    );

    always_comb begin
        winner = '0;
        for (int p = 0; p < NPROC; p++)
            if (arb_grant[p]) winner = OWN_W'(p);
    end

    // Snoop write-back (another cache holds the line in M) and owner victim
    // eviction (owner's slot is M for a different tag).
    idx_t  bidx;
    tag_t  btag;
    logic  snoop_wb;
    data_t snoop_data;
    logic  victim_wb;
    data_t fill_data;

    assign bidx = idx_of(addr_r);
    assign btag = tag_of(addr_r);

    always_comb begin
        snoop_wb   = 1'b0;
        snoop_data = '0;
        for (int q = 0; q < NPROC; q++) begin
            if (state == ST_SNOOP && owner != OWN_W'(q) && msg != MSG_UPGR &&
                line_state[q][bidx] == MSI_M && line_tag[q][bidx] == btag) begin
                snoop_wb   = 1'b1;
                snoop_data = line_data[q][bidx];
            end
        end
        victim_wb = (state == ST_FILL) && (line_state[owner][bidx] == MSI_M) &&
                    (line_tag[owner][bidx] != btag);
        // A write fills the whole word, so only BusRd takes memory data.
        fill_data = (msg == MSG_BUSRD) ? mem[addr_r] : p_wdata[owner];
    end

    assign wb_valid  = snoop_wb | victim_wb;
    assign bus_grant = in_txn ? (ONE_HOT0 << owner) : '0;
    assign bus_msg   = in_txn ? msg : MSG_NONE;
    assign bus_addr  = in_txn ? addr_r : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            msg       <= MSG_NONE;
            addr_r    <= '0;
            req_ready <= '0;
            resp_data <= '0;
            // NOTE: cache and memory arrays are reset on purpose: coherence
            // relies on known contents, so these stay flops, not RAM macros.
            for (int p = 0; p < NPROC; p++) begin
                for (int l = 0; l < LINES; l++) begin
                    line_state[p][l] <= MSI_I;
                    line_tag[p][l]   <= '0;
                    line_data[p][l]  <= '0;
                end
            end
            for (int a = 0; a < MEM_WORDS; a++)
                mem[a] <= data_t'(a);
        end else begin
            req_ready <= '0;

            // Local hits; stalled while other caches are being snooped.
            for (int p = 0; p < NPROC; p++) begin
                if (hit[p] && state != ST_SNOOP) begin
                    req_ready[p] <= 1'b1;
                    if (req_write[p]) begin
                        line_data[p][idx_of(p_addr[p])] <= p_wdata[p];
                        resp_data[p*DATA_W +: DATA_W]   <= p_wdata[p];
                    end else begin
                        resp_data[p*DATA_W +: DATA_W]   <= line_data[p][idx_of(p_addr[p])];
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|arb_grant) begin
                        owner  <= winner;
                        msg    <= need_msg[winner];
                        addr_r <= p_addr[winner];
                        state  <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    for (int q = 0; q < NPROC; q++) begin
                        if (owner != OWN_W'(q) && line_tag[q][bidx] == btag) begin
                            if (line_state[q][bidx] == MSI_M && msg == MSG_BUSRD)
                                line_state[q][bidx] <= MSI_S;
                            else if (line_state[q][bidx] != MSI_I && msg != MSG_BUSRD)
                                line_state[q][bidx] <= MSI_I;
                        end
                    end
                    if (snoop_wb)
                        mem[addr_r] <= snoop_data;
                    state <= ST_FILL;
                end
                ST_FILL: begin
                    if (victim_wb)
                        mem[addr_of(line_tag[owner][bidx], bidx)] <= line_data[owner][bidx];
                    line_tag[owner][bidx]   <= btag;
                    line_state[owner][bidx] <= (msg == MSG_BUSRD) ? MSI_S : MSI_M;
                    line_data[owner][bidx]  <= fill_data;
                    req_ready[owner]        <= 1'b1;
                    resp_data[int'(owner)*DATA_W +: DATA_W] <= fill_data;
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_msi_bus.sv
// ---------------------------------------------------------------------------
// tb_snoop_msi_bus
// Directed self-checking bench for snoop_msi_bus (NPROC=3, ADDR_W=4,
// DATA_W=4, LINES=4; index = addr[1:0], tag = addr[3:2]). Latencies are
// measured from the cycle a request is driven to the cycle req_ready shows.
// ---------------------------------------------------------------------------
module tb_snoop_msi_bus;
    localparam int NPROC  = 3;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int LINES  = 4;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NPROC-1:0]        req_valid = '0;
    logic [NPROC-1:0]        req_write = '0;
    logic [NPROC*ADDR_W-1:0] req_addr  = '0;
    logic [NPROC*DATA_W-1:0] req_wdata = '0;
    logic [NPROC-1:0]        req_ready;
    logic [NPROC*DATA_W-1:0] resp_data;
    logic [NPROC-1:0]        bus_grant;
    logic [1:0]              bus_msg;
    logic [ADDR_W-1:0]       bus_addr;
    logic                    wb_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    snoop_msi_bus #(
        .NPROC(NPROC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_data (resp_data),
        .bus_grant (bus_grant),
        .bus_msg   (bus_msg),
        .bus_addr  (bus_addr),
        .wb_valid  (wb_valid)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ready"}, int'(req_ready), 0);
        check({name, "_resp"},  int'(resp_data), 0);
        check({name, "_grant"}, int'(bus_grant), 0);
        check({name, "_msg"},   int'(bus_msg),   0);
        check({name, "_addr"},  int'(bus_addr),  0);
        check({name, "_wb"},    int'(wb_valid),  0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic issue(input int p, input bit w, input int a, input int d);
        req_write[p]                  = w;
        req_addr[p*ADDR_W +: ADDR_W]  = ADDR_W'(a);
        req_wdata[p*DATA_W +: DATA_W] = DATA_W'(d);
        req_valid[p]                  = 1'b1;
    endtask

    // One request; records latency, data, first bus message/address/grant
    // and the offset of the first write-back. Ends with the bus back in IDLE.
    task automatic txn(input int p, input bit w, input int a, input int d,
                       output int lat, output int data, output int msg,
                       output int wb_at, output int baddr, output int grant);
        int t0;
        issue(p, w, a, d);
        t0 = cyc;
        lat = -1; data = -1; msg = 0; wb_at = -1; baddr = -1; grant = 0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clock);
            if (msg == 0 && bus_msg != 2'd0) begin
                msg   = int'(bus_msg);
                baddr = int'(bus_addr);
                grant = int'(bus_grant);
            end
            if (wb_valid && wb_at < 0) wb_at = cyc - t0;
            if (req_ready[p]) begin
                lat  = cyc - t0;
                data = int'(resp_data[p*DATA_W +: DATA_W]);
            end
        end
        req_valid[p] = 1'b0;
        @(negedge clock);
    endtask

    task automatic run(input string name, input int p, input bit w, input int a,
                       input int d, input int exp_lat, input int exp_data,
                       input int exp_msg, input int exp_wb);
        int lat, data, msg, wb_at, baddr, grant;
        txn(p, w, a, d, lat, data, msg, wb_at, baddr, grant);
        check({name, "_lat"},  lat,   exp_lat);
        check({name, "_data"}, data,  exp_data);
        check({name, "_msg"},  msg,   exp_msg);
        check({name, "_wb"},   wb_at, exp_wb);
        if (exp_msg != 0) begin
            check({name, "_baddr"}, baddr, a);
            check({name, "_grant"}, grant, 1 << p);
        end
    endtask

    // All three processors read-miss in the same cycle.
    task automatic round(input string name, input int a0, input int a1, input int a2);
        int t0;
        int ack [NPROC];
        int dat [NPROC];
        int exp_dat [NPROC];
        int order [$];
        logic [NPROC-1:0] prev;
        exp_dat[0] = a0; exp_dat[1] = a1; exp_dat[2] = a2;
        for (int p = 0; p < NPROC; p++) begin
            ack[p] = -1;
            dat[p] = -1;
            issue(p, 1'b0, exp_dat[p], 0);
        end
        t0   = cyc;
        prev = '0;
        for (int k = 0; k < 40 && req_valid != '0; k++) begin
            @(negedge clock);
            if (bus_grant != '0 && prev == '0)
                for (int i = 0; i < NPROC; i++)
                    if (bus_grant[i]) order.push_back(i);
            prev = bus_grant;
            for (int p = 0; p < NPROC; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    ack[p]       = cyc - t0;
                    dat[p]       = int'(resp_data[p*DATA_W +: DATA_W]);
                    req_valid[p] = 1'b0;
                end
            end
        end
        req_valid = '0;
        @(negedge clock);
        check($sformatf("%s_ngrants", name), order.size(), NPROC);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("%s_order%0d", name, i), order[i], i);
        for (int p = 0; p < NPROC; p++) begin
            check($sformatf("%s_ack%0d", name, p),  ack[p], 3 + 4 * p);
            check($sformatf("%s_data%0d", name, p), dat[p], exp_dat[p]);
        end
    endtask

    initial begin
        // Reset state.
        do_reset();
        check_quiet("reset");

        // BusRd fill, then S hit.
        run("p0_rd5",      0, 1'b0, 5, 0, 3, 5, 1, -1);
        run("p0_rd5_hit",  0, 1'b0, 5, 0, 1, 5, 0, -1);
        // Upgrade S->M, then a write hit shows M.
        run("p0_upgr",     0, 1'b1, 5, 9, 3, 9, 3, -1);
        run("p0_wr_hit",   0, 1'b1, 5, 9, 1, 9, 0, -1);
        // P1 read forces P0's M copy back to memory in SNOOP.
        run("p1_rd5",      1, 1'b0, 5, 0, 3, 9, 1, 1);
        run("p0_rd5_s",    0, 1'b0, 5, 0, 1, 9, 0, -1);
        // P2 write miss invalidates both sharers.
        run("p2_wr3",      2, 1'b1, 5, 3, 3, 3, 2, -1);
        run("p0_rd5_inv",  0, 1'b0, 5, 0, 3, 3, 1, 1);
        run("p1_rd5_inv",  1, 1'b0, 5, 0, 3, 3, 1, -1);

        // Simultaneous misses, two rounds, each restarting from P0.
        do_reset();
        round("rr1", 2, 6, 10);
        round("rr2", 3, 7, 11);

        // Victim write-back in FILL.
        do_reset();
        run("p0_wr7_a1",   0, 1'b1, 1, 7, 3, 7, 2, -1);
        run("p0_rd5_vict", 0, 1'b0, 5, 0, 3, 5, 1, 2);
        run("p1_rd1_mem",  1, 1'b0, 1, 0, 3, 7, 1, -1);

        // Reset during FILL aborts the transaction and restores everything.
        issue(0, 1'b0, 9, 0);
        @(negedge clock);
        check("abort_snoop_grant", int'(bus_grant), 1);
        check("abort_snoop_msg",   int'(bus_msg),   1);
        check("abort_snoop_addr",  int'(bus_addr),  9);
        @(negedge clock);
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clock);
        check_quiet("abort");
        reset = 1'b0;
        run("post_p1_rd1", 1, 1'b0, 1, 0, 3, 1, 1, -1);
        run("post_p0_rd5", 0, 1'b0, 5, 0, 3, 5, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
